pipe_phy_control: RTL and testbench
===================================

Name: pipe_phy_control

Overview:
- PHY-side responder for the PIPE control interface; the counterpart of the MAC-side LTSSM PIPE controller.
- Consumes PowerDown, TxDetectRx_Loopback and TxElecIdle.
- Produces PhyStatus/RxStatus handshakes for power-state changes and receiver detection.
- Sits in the PHY model between the PIPE boundary and the per-lane analog/termination model; used both in silicon-model RTL and as a verification responder for the MAC.

Parameters:
- number_of_lanes, 4, lane count; width of rx_present and rx_detected.
- RESET_LAT, 16, cycles PhyStatus stays high after reset release (PLL lock model); range 1..255.
- POWER_LAT, 4, cycles from sampling a new PowerDown value to the PhyStatus pulse; range 1..255.
- DETECT_LAT, 8, cycles from sampling a TxDetectRx rise to the detect-result PhyStatus pulse; range 1..255.

Ports:
- pclk  input  1  PIPE clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- PowerDown  input  4  requested power state: 0=P0, 1=P0s, 2=P1, 3=P2; 4..15 invalid.
- TxDetectRx_Loopback  input  1  receiver-detect request (level).
- TxElecIdle  input  1  MAC transmitter electrical-idle request.
- rx_present  input  number_of_lanes  far-end termination present, per lane.
- PhyStatus  output  1  PIPE completion / PLL-not-ready indication.
- RxStatus  output  3  3'b011 = receiver detected, 3'b000 otherwise.
- rx_detected  output  number_of_lanes  per-lane detect result, latched at completion.
- power_state  output  4  currently active power state.
- tx_idle_out  output  1  registered TxElecIdle forwarded to the lane drivers.

Behaviour:
- Reset (reset=1 at an edge): PhyStatus=1, RxStatus=000, rx_detected=0, power_state=2, tx_idle_out=1, counter=0, state=RESET_WAIT.
- FSM states: RESET_WAIT, IDLE, PD_CHANGE, DETECT_RUN, DETECT_DONE. An 8-bit down-counter is shared by all timed states.
- RESET_WAIT: counter is loaded with RESET_LAT-1 when reset is released.
  - PhyStatus stays 1 while counter>0.
  - On the edge where counter==0: PhyStatus<=0 and state<=IDLE.
  - PowerDown and TxDetectRx are ignored in this state.
- IDLE, priority order:
  1. PowerDown valid (<=3) and !=power_state: load POWER_LAT-1, latch target, go to PD_CHANGE.
  2. Else if TxDetectRx_Loopback==1, power_state==2 and TxElecIdle==1: load DETECT_LAT-1, go to DETECT_RUN.
  3. Else stay in IDLE.
  - Detect requests in any other power state, or with TxElecIdle=0, get no response.
  - Invalid PowerDown values are ignored: no state change, no PhyStatus.
- PD_CHANGE: count down. On counter==0: power_state<=target, PhyStatus<=1 for exactly one cycle, return to IDLE.
  - PowerDown changes while in PD_CHANGE are not tracked; they are re-evaluated in IDLE afterwards.
- DETECT_RUN: count down. On counter==0: go to DETECT_DONE.
  - In the same edge: rx_detected<=rx_present sampled at that edge; PhyStatus<=1 (one cycle).
  - RxStatus<=011 if any rx_present bit is 1, else 000.
- DETECT_DONE: RxStatus holds its value until TxDetectRx_Loopback==0 is sampled; then RxStatus<=000 and state<=IDLE. rx_detected holds until the next detect or reset.
  - Detect never completes twice without an intervening TxDetectRx deassert.
- Coincidence rule: PhyStatus and RxStatus=011 are valid in the same cycle while TxDetectRx is still 1, so the MAC can qualify all three together.
- tx_idle_out: registered TxElecIdle, 1-cycle latency; forced to 1 while power_state is 2 or 3.
- Reset mid-operation aborts any state; reset values apply on the next edge.

Decomposition:
- Shared package pipe_pkg holds:
  - power-state constants P0=0, P0s=1, P1=2, P2=3;
  - RxStatus codes RXS_OK=3'b000, RXS_DETECTED=3'b011;
  - the FSM state encoding.
- One natural sub-module: pipe_latency_timer (load/decrement/zero flag, 8-bit), instantiated once.

Test Plan:
- Reset release with RESET_LAT=16 -> PhyStatus=1 for exactly 16 cycles after the release edge, then 0; power_state=2, RxStatus=000.
- Detect, all lanes present: PowerDown=2, TxElecIdle=1, TxDetectRx 0->1, rx_present=4'b1111 -> after 8 cycles a one-cycle PhyStatus with RxStatus=011 and rx_detected=1111. Deassert TxDetectRx -> RxStatus=000 next cycle.
- Detect, no receiver: same stimulus with rx_present=0 -> PhyStatus pulse with RxStatus=000, rx_detected=0.
- Power change: PowerDown 2->0 -> PhyStatus one-cycle pulse 4 cycles after sampling, power_state=0. PowerDown=7 -> no pulse, power_state unchanged.
- Simultaneous events and disallowed detect: PowerDown 2->0 and TxDetectRx rise in the same cycle -> power change wins; detect is ignored (P0). With TxElecIdle=0 in P1 -> no PhyStatus response.
- Reset asserted mid-DETECT_RUN -> PhyStatus=1 and RxStatus=000 next cycle; the full RESET_LAT sequence repeats.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared power-state, RxStatus and FSM encodings for the PIPE PHY responder
package pipe_pkg;
    localparam logic [3:0] P0  = 4'd0;
    localparam logic [3:0] P0s = 4'd1;
    localparam logic [3:0] P1  = 4'd2;
    localparam logic [3:0] P2  = 4'd3;
    localparam logic [2:0] RXS_OK       = 3'b000;
    localparam logic [2:0] RXS_DETECTED = 3'b011;
    typedef enum logic [2:0] {
        RESET_WAIT,
        IDLE,
        PD_CHANGE,
        DETECT_RUN,
        DETECT_DONE
    } state_t;
endpackage

// File: rtl/pipe_latency_timer.sv
// pipe_latency_timer: 8-bit loadable down-counter with zero flag, shared by all timed states
module pipe_latency_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       zero
);
    logic [7:0] count;
    // load has priority; otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != 8'd0)
            count <= count - 8'd1;
    end
    assign zero = (count == 8'd0);
endmodule

// File: rtl/pipe_phy_control.sv
// pipe_phy_control: PHY-side PIPE responder producing PhyStatus/RxStatus for power changes and receiver detect
module pipe_phy_control
    import pipe_pkg::*;
#(
    parameter int number_of_lanes = 4,
    parameter int RESET_LAT       = 16,
    parameter int POWER_LAT       = 4,
    parameter int DETECT_LAT      = 8
) (
    input  logic                       pclk,
    input  logic                       reset,
    input  logic [3:0]                 PowerDown,
    input  logic                       TxDetectRx_Loopback,
    input  logic                       TxElecIdle,
    input  logic [number_of_lanes-1:0] rx_present,
    output logic                       PhyStatus,
    output logic [2:0]                 RxStatus,
    output logic [number_of_lanes-1:0] rx_detected,
    output logic [3:0]                 power_state,
    output logic                       tx_idle_out
);
    state_t                     state, state_n;
    logic                       released;
    logic                       phy_n;
    logic [2:0]                 rxs_n;
    logic [number_of_lanes-1:0] det_n;
    logic [3:0]                 ps_n, target, target_n;
    logic                       load, zero;
    logic [7:0]                 load_val;

    pipe_latency_timer u_timer (
        .clk      (pclk),
        .rst      (reset),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );

    // state and output registers; released marks the first edge after reset deasserts
    always_ff @(posedge pclk) begin
        if (reset) begin
            state       <= RESET_WAIT;
            released    <= 1'b0;
            PhyStatus   <= 1'b1;
            RxStatus    <= RXS_OK;
            rx_detected <= '0;
            power_state <= P1;
            target      <= P1;
            tx_idle_out <= 1'b1;
        end else begin
            state       <= state_n;
            released    <= 1'b1;
            PhyStatus   <= phy_n;
            RxStatus    <= rxs_n;
            rx_detected <= det_n;
            power_state <= ps_n;
            target      <= target_n;
            tx_idle_out <= TxElecIdle | power_state[1];
        end
    end

    // next-state, timer control and next output values
    always_comb begin
        state_n  = state;
        phy_n    = 1'b0;
        rxs_n    = RxStatus;
        det_n    = rx_detected;
        ps_n     = power_state;
        target_n = target;
        load     = 1'b0;
        load_val = 8'd0;
        case (state)
            RESET_WAIT: begin
                if (!released) begin
                    load     = 1'b1;
                    load_val = 8'(RESET_LAT - 1);
                    phy_n    = 1'b1;
                end else if (zero)
                    state_n = IDLE;
                else
                    phy_n = 1'b1;
            end
            IDLE: begin
                if (PowerDown <= P2 && PowerDown != power_state) begin
                    load     = 1'b1;
                    load_val = 8'(POWER_LAT - 1);
                    target_n = PowerDown;
                    state_n  = PD_CHANGE;
                end else if (TxDetectRx_Loopback && power_state == P1 && TxElecIdle) begin
                    load     = 1'b1;
                    load_val = 8'(DETECT_LAT - 1);
                    state_n  = DETECT_RUN;
                end
            end
            PD_CHANGE: begin
                if (zero) begin
                    ps_n    = target;
                    phy_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            DETECT_RUN: begin
                if (zero) begin
                    det_n   = rx_present;
                    rxs_n   = |rx_present ? RXS_DETECTED : RXS_OK;
                    phy_n   = 1'b1;
                    state_n = DETECT_DONE;
                end
            end
            DETECT_DONE: begin
                if (!TxDetectRx_Loopback) begin
                    rxs_n   = RXS_OK;
                    state_n = IDLE;
                end
            end
            default: state_n = RESET_WAIT;
        endcase
    end
endmodule

// File: tb/tb_pipe_phy_control.sv
// tb_pipe_phy_control: directed table, corner sequences and randomized run against a deadline-based reference model
module tb_pipe_phy_control;
    localparam int NL = 4;
    localparam int RL = 16;
    localparam int PL = 4;
    localparam int DL = 8;

    logic          pclk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    PowerDown = 4'd2;
    logic          TxDetectRx_Loopback = 1'b0;
    logic          TxElecIdle = 1'b1;
    logic [NL-1:0] rx_present = '0;
    logic          PhyStatus;
    logic [2:0]    RxStatus;
    logic [NL-1:0] rx_detected;
    logic [3:0]    power_state;
    logic          tx_idle_out;

    always #5 pclk = ~pclk;

    pipe_phy_control #(
        .number_of_lanes (NL),
        .RESET_LAT       (RL),
        .POWER_LAT       (PL),
        .DETECT_LAT      (DL)
    ) dut (
        .pclk                (pclk),
        .reset               (reset),
        .PowerDown           (PowerDown),
        .TxDetectRx_Loopback (TxDetectRx_Loopback),
        .TxElecIdle          (TxElecIdle),
        .rx_present          (rx_present),
        .PhyStatus           (PhyStatus),
        .RxStatus            (RxStatus),
        .rx_detected         (rx_detected),
        .power_state         (power_state),
        .tx_idle_out         (tx_idle_out)
    );

    int errors = 0;
    int checks = 0;
    int t = 0;

    // reference model: each pending operation is a deadline in absolute cycle numbers
    localparam int OP_FREE = 0, OP_BOOT = 1, OP_PWR = 2, OP_DET = 3, OP_HOLD = 4;
    int            m_op = OP_BOOT;
    int            m_due = -1;
    logic [3:0]    m_tgt = 4'd2;
    logic [3:0]    m_ps = 4'd2;
    logic          m_phy = 1'b1;
    logic [2:0]    m_rxs = 3'd0;
    logic [NL-1:0] m_det = '0;
    logic          m_txi = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, t, act, exp);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_ps = 4'd2; m_phy = 1'b1; m_rxs = 3'd0; m_det = '0; m_txi = 1'b1;
            m_op = OP_BOOT; m_due = -1;
        end else begin
            m_txi = TxElecIdle || (m_ps >= 4'd2);
            m_phy = 1'b0;
            if (m_op == OP_BOOT) begin
                if (m_due < 0) m_due = t + RL;
                if (t < m_due) m_phy = 1'b1;
                else m_op = OP_FREE;
            end else if (m_op == OP_PWR) begin
                if (t == m_due) begin
                    m_ps = m_tgt; m_phy = 1'b1; m_op = OP_FREE;
                end
            end else if (m_op == OP_DET) begin
                if (t == m_due) begin
                    m_det = rx_present;
                    m_rxs = (rx_present != 0) ? 3'b011 : 3'b000;
                    m_phy = 1'b1;
                    m_op = OP_HOLD;
                end
            end else if (m_op == OP_HOLD) begin
                if (!TxDetectRx_Loopback) begin
                    m_rxs = 3'd0; m_op = OP_FREE;
                end
            end else begin
                if (PowerDown <= 4'd3 && PowerDown != m_ps) begin
                    m_tgt = PowerDown; m_due = t + PL; m_op = OP_PWR;
                end else if (TxDetectRx_Loopback && m_ps == 4'd2 && TxElecIdle) begin
                    m_due = t + DL; m_op = OP_DET;
                end
            end
        end
    endtask

    // one clock: model follows the edge, outputs are compared on the falling edge
    task automatic step();
        @(posedge pclk);
        t++;
        model_edge();
        @(negedge pclk);
        chk("model_phystatus", int'(PhyStatus), int'(m_phy));
        chk("model_rxstatus", int'(RxStatus), int'(m_rxs));
        chk("model_rx_detected", int'(rx_detected), int'(m_det));
        chk("model_power_state", int'(power_state), int'(m_ps));
        chk("model_tx_idle_out", int'(tx_idle_out), int'(m_txi));
    endtask

    // releases reset and measures how many cycles PhyStatus stays high from the release edge
    task automatic boot_check(input string name);
        int n;
        reset = 1'b0;
        step();
        n = 0;
        while (PhyStatus === 1'b1 && n < 300) begin
            n++;
            step();
        end
        chk(name, n, RL);
        chk({name, "_ps"}, int'(power_state), 2);
        chk({name, "_rxs"}, int'(RxStatus), 0);
    endtask

    typedef struct {
        logic [3:0]    pd;
        logic          td;
        logic          ei;
        logic [NL-1:0] rxp;
        int            n;
        logic          phy;
        logic [2:0]    rxs;
        logic [NL-1:0] det;
        logic [3:0]    ps;
        logic          txi;
    } vec_t;

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{4'd2, 1'b1, 1'b1, 4'hF, 8,  1'b0, 3'd0, 4'h0, 4'd2, 1'b1};
        tbl[1]  = '{4'd2, 1'b1, 1'b1, 4'hF, 1,  1'b1, 3'd3, 4'hF, 4'd2, 1'b1};
        tbl[2]  = '{4'd2, 1'b1, 1'b1, 4'hF, 1,  1'b0, 3'd3, 4'hF, 4'd2, 1'b1};
        tbl[3]  = '{4'd2, 1'b0, 1'b1, 4'hF, 1,  1'b0, 3'd0, 4'hF, 4'd2, 1'b1};
        tbl[4]  = '{4'd2, 1'b1, 1'b1, 4'h0, 9,  1'b1, 3'd0, 4'h0, 4'd2, 1'b1};
        tbl[5]  = '{4'd2, 1'b0, 1'b1, 4'h0, 2,  1'b0, 3'd0, 4'h0, 4'd2, 1'b1};
        tbl[6]  = '{4'd0, 1'b0, 1'b1, 4'h0, 4,  1'b0, 3'd0, 4'h0, 4'd2, 1'b1};
        tbl[7]  = '{4'd0, 1'b0, 1'b1, 4'h0, 1,  1'b1, 3'd0, 4'h0, 4'd0, 1'b1};
        tbl[8]  = '{4'd0, 1'b0, 1'b1, 4'h0, 1,  1'b0, 3'd0, 4'h0, 4'd0, 1'b1};
        tbl[9]  = '{4'd7, 1'b0, 1'b0, 4'h0, 6,  1'b0, 3'd0, 4'h0, 4'd0, 1'b0};
        tbl[10] = '{4'd2, 1'b0, 1'b1, 4'h0, 5,  1'b1, 3'd0, 4'h0, 4'd2, 1'b1};
        tbl[11] = '{4'd2, 1'b0, 1'b1, 4'h0, 1,  1'b0, 3'd0, 4'h0, 4'd2, 1'b1};
        tbl[12] = '{4'd0, 1'b1, 1'b1, 4'hF, 5,  1'b1, 3'd0, 4'h0, 4'd0, 1'b1};
        tbl[13] = '{4'd0, 1'b1, 1'b1, 4'hF, 3,  1'b0, 3'd0, 4'h0, 4'd0, 1'b1};
        tbl[14] = '{4'd2, 1'b0, 1'b1, 4'hF, 5,  1'b1, 3'd0, 4'h0, 4'd2, 1'b1};
        tbl[15] = '{4'd2, 1'b0, 1'b1, 4'hF, 1,  1'b0, 3'd0, 4'h0, 4'd2, 1'b1};
        tbl[16] = '{4'd2, 1'b1, 1'b0, 4'hF, 12, 1'b0, 3'd0, 4'h0, 4'd2, 1'b1};

        step();
        step();
        chk("reset_phystatus", int'(PhyStatus), 1);
        chk("reset_power_state", int'(power_state), 2);
        chk("reset_tx_idle_out", int'(tx_idle_out), 1);
        boot_check("boot_len");

        for (int i = 0; i < 17; i++) begin
            PowerDown = tbl[i].pd;
            TxDetectRx_Loopback = tbl[i].td;
            TxElecIdle = tbl[i].ei;
            rx_present = tbl[i].rxp;
            for (int k = 0; k < tbl[i].n; k++) step();
            chk($sformatf("vec%0d_phystatus", i), int'(PhyStatus), int'(tbl[i].phy));
            chk($sformatf("vec%0d_rxstatus", i), int'(RxStatus), int'(tbl[i].rxs));
            chk($sformatf("vec%0d_rx_detected", i), int'(rx_detected), int'(tbl[i].det));
            chk($sformatf("vec%0d_power_state", i), int'(power_state), int'(tbl[i].ps));
            chk($sformatf("vec%0d_tx_idle_out", i), int'(tx_idle_out), int'(tbl[i].txi));
        end

        TxElecIdle = 1'b1;
        TxDetectRx_Loopback = 1'b1;
        rx_present = 4'b0101;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        chk("midreset_phystatus", int'(PhyStatus), 1);
        chk("midreset_rxstatus", int'(RxStatus), 0);
        chk("midreset_power_state", int'(power_state), 2);
        TxDetectRx_Loopback = 1'b0;
        boot_check("reboot_len");

        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0)
                PowerDown = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) TxDetectRx_Loopback = ~TxDetectRx_Loopback;
            if ($urandom_range(0, 7) == 0) TxElecIdle = ~TxElecIdle;
            rx_present = NL'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
